// File: rtl/alu16_issue_ctrl_if.sv
// Request, ALU-drive and response signals of the ALU issue stage.
// The slave modport is the issue controller; the master modport is the requester/ALU side.
interface alu16_issue_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_cin;
    logic             alu_ainvert;
    logic             alu_bnegate;
    logic             alu_less;
    logic [1:0]       alu_op;
    logic [WIDTH-1:0] alu_result;
    logic             alu_cout;
    logic             alu_zero;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_cout;
    logic             rsp_zero;
    logic             rsp_overflow;
    logic             rsp_illegal;

    modport slave (
        input  req_valid, req_op, req_a, req_b,
        output req_ready,
        output alu_a, alu_b, alu_cin, alu_ainvert, alu_bnegate, alu_less, alu_op,
        input  alu_result, alu_cout, alu_zero,
        output rsp_valid, rsp_result, rsp_cout, rsp_zero, rsp_overflow, rsp_illegal,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_op, req_a, req_b,
        input  req_ready,
        input  alu_a, alu_b, alu_cin, alu_ainvert, alu_bnegate, alu_less, alu_op,
        output alu_result, alu_cout, alu_zero,
        input  rsp_valid, rsp_result, rsp_cout, rsp_zero, rsp_overflow, rsp_illegal,
        output rsp_ready
    );
endinterface

// File: rtl/alu16_issue_ctrl.sv
// Issue stage for the 16-bit ALU: registers a request, sequences the ALU controls, adds signed overflow.
// Latency 2 edges after accept (3 for SLT); one op in flight, response held until rsp_ready.
// ALU16_SLT_EN enables the two-pass set-less-than; without it op 101 is reported illegal.
module alu16_issue_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    alu16_issue_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, EXEC, SLT2, DONE} state_t;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;

    state_t           state_q, state_d;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             settle_q;
    logic [WIDTH-1:0] res_q;
    logic             cout_q, zero_q, ovf_q, ill_q;

    logic             illegal;
    logic             is_slt;
    logic             ovf_add, ovf_sub;
    logic             ctl_ainv, ctl_bneg, ctl_cin, ctl_less;
    logic [1:0]       ctl_op;

`ifdef ALU16_SLT_EN
    logic slt_q;
    assign is_slt  = (op_q == OP_SLT);
    assign illegal = (op_q == 3'b110) || (op_q == 3'b111);
`else
    assign is_slt  = 1'b0;
    assign illegal = (op_q == 3'b110) || (op_q == 3'b111) || (op_q == OP_SLT);
`endif

    assign ovf_add = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (bus.alu_result[WIDTH-1] != a_q[WIDTH-1]);
    assign ovf_sub = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (bus.alu_result[WIDTH-1] != a_q[WIDTH-1]);

    // Controls come only from registered state so the ALU sees stable inputs for the whole EXEC pass.
    always_comb begin
        ctl_ainv = 1'b0;
        ctl_bneg = 1'b0;
        ctl_cin  = 1'b0;
        ctl_less = 1'b0;
        ctl_op   = 2'b00;
        if (state_q == EXEC && !illegal) begin
            unique case (op_q)
                OP_AND: ctl_op = 2'b00;
                OP_OR:  ctl_op = 2'b01;
                OP_ADD: ctl_op = 2'b10;
                OP_SUB, OP_SLT: begin
                    ctl_op   = 2'b10;
                    ctl_bneg = 1'b1;
                    ctl_cin  = 1'b1;
                end
                OP_NOR: begin
                    ctl_ainv = 1'b1;
                    ctl_bneg = 1'b1;
                end
                default: ctl_op = 2'b00;
            endcase
        end
`ifdef ALU16_SLT_EN
        else if (state_q == SLT2) begin
            ctl_op   = 2'b11;
            ctl_less = slt_q;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (bus.req_valid) state_d = EXEC;
            EXEC: if (settle_q)      state_d = is_slt ? SLT2 : DONE;
            SLT2: state_d = DONE;
            DONE: if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // EXEC spans two cycles: the first lets the ALU settle, the second samples it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= 3'b000;
            a_q      <= '0;
            b_q      <= '0;
            settle_q <= 1'b0;
            res_q    <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            ill_q    <= 1'b0;
`ifdef ALU16_SLT_EN
            slt_q    <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: if (bus.req_valid) begin
                    op_q     <= bus.req_op;
                    a_q      <= bus.req_a;
                    b_q      <= bus.req_b;
                    settle_q <= 1'b0;
                end
                EXEC: if (!settle_q) begin
                    settle_q <= 1'b1;
                end else if (illegal) begin
                    res_q  <= '0;
                    cout_q <= 1'b0;
                    zero_q <= 1'b0;
                    ovf_q  <= 1'b0;
                    ill_q  <= 1'b1;
                end else if (is_slt) begin
`ifdef ALU16_SLT_EN
                    slt_q  <= bus.alu_result[WIDTH-1] ^ ovf_sub;
`endif
                    cout_q <= 1'b0;
                    ovf_q  <= 1'b0;
                    ill_q  <= 1'b0;
                end else begin
                    res_q  <= bus.alu_result;
                    cout_q <= bus.alu_cout;
                    zero_q <= bus.alu_zero;
                    ovf_q  <= (op_q == OP_ADD) ? ovf_add :
                              (op_q == OP_SUB) ? ovf_sub : 1'b0;
                    ill_q  <= 1'b0;
                end
                SLT2: begin
                    res_q  <= bus.alu_result;
                    zero_q <= bus.alu_zero;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready    = (state_q == IDLE);
    assign bus.rsp_valid    = (state_q == DONE);
    assign bus.alu_a        = a_q;
    assign bus.alu_b        = b_q;
    assign bus.alu_ainvert  = ctl_ainv;
    assign bus.alu_bnegate  = ctl_bneg;
    assign bus.alu_cin      = ctl_cin;
    assign bus.alu_op       = ctl_op;
`ifdef ALU16_SLT_EN
    assign bus.alu_less     = ctl_less;
`else
    assign bus.alu_less     = 1'b0;
`endif
    assign bus.rsp_result   = res_q;
    assign bus.rsp_cout     = cout_q;
    assign bus.rsp_zero     = zero_q;
    assign bus.rsp_overflow = ovf_q;
    assign bus.rsp_illegal  = ill_q;

    logic unused_ok;
    assign unused_ok = ctl_less;
endmodule

// File: doc/alu16_issue_ctrl.md
# alu16_issue_ctrl

- Sequencing stage directly upstream of the 16-bit ALU (`alu16Bit`).
- Accepts one operation request at a time over a valid/ready handshake and registers the operands. It then drives the ALU's control lines (ainvert, bnegate, cin, less, op) and captures the ALU's result, cout and zero.
- Computes signed overflow, which the ALU does not produce, and returns everything on a valid/ready response port.
- Set-less-than is executed as a two-pass sequence: subtract, then a less-pass.

## Interface

Parameters:
- `WIDTH`, default 16: datapath width. Must match the ALU.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_op`  in  3  operation code:
  - 000 AND, 001 OR, 010 ADD, 011 SUB, 100 NOR, 101 SLT.
  - 110 and 111 are illegal.
- `req_a`, `req_b`  in  WIDTH  operands.
- `alu_a`, `alu_b`  out  WIDTH  registered operands to the ALU.
- `alu_cin`, `alu_ainvert`, `alu_bnegate`, `alu_less`  out  1  ALU controls.
- `alu_op`  out  2  ALU function select: 00 AND, 01 OR, 10 ADD, 11 less-pass.
- `alu_result`  in  WIDTH  ALU output.
- `alu_cout`, `alu_zero`  in  1  ALU flags.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_result`  out  WIDTH  captured result.
- `rsp_cout`, `rsp_zero`, `rsp_overflow`, `rsp_illegal`  out  1  captured flags.

## Operation

- States: IDLE, EXEC, SLT2, DONE.

- **IDLE**
  - `req_ready`=1.
  - On `req_valid & req_ready`: latch `req_a`, `req_b` and `req_op`, then go to EXEC.

- **ALU control mapping** (all driven from registered state, never directly from `req_*`):
  - AND: op 00, all other controls 0.
  - OR: op 01, all other controls 0.
  - ADD: op 10, cin 0.
  - SUB: op 10, bnegate 1, cin 1.
  - NOR: op 00, ainvert 1, bnegate 1, cin 0.
  - SLT pass 1: same as SUB.
  - SLT pass 2: op 11, less = slt bit, all other controls 0.
  - Illegal op: all controls 0.

- **EXEC**
  - Single-pass ops: capture `alu_result`, `alu_cout`, `alu_zero` and the computed overflow into the response registers, then go to DONE.
  - SLT: compute `slt = alu_result[WIDTH-1] ^ ovf_sub` and hold it in a register, then go to SLT2.
  - Illegal op: result 0, all flags 0, `rsp_illegal`=1, go to DONE.

- **SLT2**
  - Capture `alu_result` and `alu_zero`, then go to DONE.
  - For SLT, `rsp_cout` and `rsp_overflow` are both 0.

- **DONE**
  - `rsp_valid`=1.
  - On `rsp_ready`, go to IDLE.
  - Response registers hold stable while `rsp_ready`=0.

- **Overflow rules** (a = `alu_a`, r = `alu_result`):
  - ADD: `a[W-1]==b[W-1] && r[W-1]!=a[W-1]`.
  - SUB and SLT pass 1: `a[W-1]!=b[W-1] && r[W-1]!=a[W-1]`.
  - All other ops: 0.

- **Carry rule**: `rsp_cout` is the raw ALU carry. For SUB, 1 means no borrow.

## Timing

- Reset (asynchronous, takes effect immediately):
  - State goes to IDLE.
  - Every output returns to 0, except `req_ready`, which is 1 once in IDLE.
  - An in-flight operation is discarded and no response is issued.
- Latency from the accept edge N:
  - Single-pass ops: `rsp_valid` rises after edge N+2.
  - SLT: `rsp_valid` rises after edge N+3.
- `req_ready`=0 in EXEC, SLT2 and DONE. A request held during those states is accepted on the first IDLE cycle.
- Response handshake at edge M (`rsp_valid & rsp_ready`): `rsp_valid` falls after M, and `req_ready` is 1 in the cycle after M.
- ALU outputs are sampled at the end of the cycle in which the ALU is driven. The ALU is purely combinational, with one cycle allowed for it.

## Configuration

- Macro: `ALU16_SLT_EN`.
- Defined: SLT is supported via the EXEC→SLT2 two-pass sequence.
- Undefined:
  - State SLT2 and the slt register are not synthesised.
  - `req_op`=101 is treated as illegal: 2-cycle latency, `rsp_illegal`=1, result 0.
  - `alu_less` is tied to 0.

## Test plan

- ADD `a`=0x000F, `b`=0x000E; accepted at edge N:
  - `rsp_valid` after N+2.
  - result 0x001D; cout 0, zero 0, overflow 0.
- SUB `a`=1001, `b`=12341:
  - result 0xD3B4, cout 0, overflow 0.
- SUB `a`=0x000F, `b`=0x000E:
  - result 0x0001, cout 1.
- ADD `a`=0x7FFF, `b`=0x0001:
  - result 0x8000, overflow 1.
- NOR `a`=2, `b`=1:
  - result 0xFFFC, zero 0.
- NOR `a`=0xFFFF, `b`=0:
  - result 0, zero 1.
- SLT `a`=0x8000, `b`=0x0001, with `ALU16_SLT_EN` defined:
  - result 0x0001, `rsp_valid` after N+3.
  - Swapping the operands gives result 0, zero 1.
- SLT `a`=0x8000, `b`=0x0001, without `ALU16_SLT_EN`:
  - `rsp_illegal` 1, result 0.
- Backpressure, illegal op and reset:
  - Hold `rsp_ready`=0 for 5 cycles: response stays stable and `req_ready`=0 throughout.
  - `req_op`=111: `rsp_illegal` 1.
  - Assert `rst` during EXEC: all outputs go to 0 immediately and no response follows.
